bitstream_serializer: RTL and testbench

Parallel-to-serial front end for the serial sequence-detector path. It accepts WIDTH-bit words over a valid/ready handshake and shifts them out one bit at a time onto the single-bit `x` line consumed by the downstream pattern-detection FSM. A one-word holding register allows back-to-back words to stream without gaps. It also keeps a running count of words sent.

---
 rtl/bitstream_serializer.sv | 157 +++++++++++++++
 tb/tb_bitstream_serializer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bitstream_serializer.sv
// bitstream_serializer: turns WIDTH-bit words into a one-bit stream on `x`.
// A single holding register lets the next word wait while the current word
// shifts, so consecutive words stream out with no idle cycle between them.
module bitstream_serializer #(
    parameter int   WIDTH     = 8,
    parameter int   DIV       = 1,
    parameter int   MSB_FIRST = 1,
    parameter logic IDLE_BIT  = 1'b0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic [31:0]      words_sent
);

    localparam int BIT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(WIDTH - 1);
    localparam logic [DIV_W-1:0] LAST_DIV = DIV_W'(DIV - 1);

    typedef enum logic {
        S_IDLE,
        S_SHIFT
    } state_t;

    state_t             state_q,      state_d;
    logic [WIDTH-1:0]   hold_q,       hold_d;
    logic               hold_full_q,  hold_full_d;
    logic [WIDTH-1:0]   sreg_q,       sreg_d;
    logic [BIT_W-1:0]   bit_q,        bit_d;
    logic [DIV_W-1:0]   div_q,        div_d;
    logic               x_valid_q,    x_valid_d;
    logic               busy_q,       busy_d;
    logic [31:0]        words_sent_q, words_sent_d;

    logic               accept;
    logic               load;
    logic [WIDTH-1:0]   sreg_shifted;
    logic               cur_bit;

    // The bit on the line always sits at the outgoing end of sreg; shifting
    // toward that end brings the next bit into place.
    always_comb begin
        if (MSB_FIRST != 0) begin
            sreg_shifted = {sreg_q[WIDTH-2:0], 1'b0};
            cur_bit      = sreg_q[WIDTH-1];
        end else begin
            sreg_shifted = {1'b0, sreg_q[WIDTH-1:1]};
            cur_bit      = sreg_q[0];
        end
    end

    // Handshake: hold is only writable while empty, and never during reset.
    assign in_ready = reset & ~hold_full_q;
    assign accept   = in_valid & in_ready;

    // Next-state logic: bit/divider sequencing, hold-to-sreg transfer, accept.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        hold_full_d  = hold_full_q;
        sreg_d       = sreg_q;
        bit_d        = bit_q;
        div_d        = div_q;
        x_valid_d    = 1'b0;
        busy_d       = busy_q;
        words_sent_d = words_sent_q;
        load         = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (hold_full_q) begin
                    load = 1'b1;
                end
            end
            S_SHIFT: begin
                if (div_q == LAST_DIV) begin
                    div_d = '0;
                    if (bit_q == LAST_BIT) begin
                        // Word complete: count it, then chain or go idle.
                        words_sent_d = words_sent_q + 32'd1;
                        if (hold_full_q) begin
                            load = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            busy_d  = 1'b0;
                        end
                    end else begin
                        bit_d     = bit_q + 1'b1;
                        sreg_d    = sreg_shifted;
                        x_valid_d = 1'b1;
                    end
                end else begin
                    div_d = div_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // Transfer the waiting word; its first bit shows on the next cycle.
        if (load) begin
            sreg_d      = hold_q;
            hold_full_d = 1'b0;
            state_d     = S_SHIFT;
            busy_d      = 1'b1;
            bit_d       = '0;
            div_d       = '0;
            x_valid_d   = 1'b1;
        end

        // in_ready is low while hold is full, so this never collides with load.
        if (accept) begin
            hold_d      = in_data;
            hold_full_d = 1'b1;
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            hold_q       <= '0;
            hold_full_q  <= 1'b0;
            sreg_q       <= '0;
            bit_q        <= '0;
            div_q        <= '0;
            x_valid_q    <= 1'b0;
            busy_q       <= 1'b0;
            words_sent_q <= '0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            hold_full_q  <= hold_full_d;
            sreg_q       <= sreg_d;
            bit_q        <= bit_d;
            div_q        <= div_d;
            x_valid_q    <= x_valid_d;
            busy_q       <= busy_d;
            words_sent_q <= words_sent_d;
        end
    end

    // Line is parked at IDLE_BIT whenever no word is in flight.
    assign x          = busy_q ? cur_bit : IDLE_BIT;
    assign x_valid    = x_valid_q;
    assign busy       = busy_q;
    assign words_sent = words_sent_q;

endmodule

// File: tb/tb_bitstream_serializer.sv
// Bench for bitstream_serializer: three instances (DIV=1 MSB-first,
// DIV=3 MSB-first, DIV=1 LSB-first) against a cycle-index reference model.
module tb_bitstream_serializer;

    logic        clk;
    logic        rst_n;
    logic [7:0]  in_data;
    logic [2:0]  iv;
    logic [2:0]  rdy, x, xv, busy;
    logic [2:0][31:0] ws;

    int errors = 0;
    int checks = 0;
    bit armed  = 0;

    bitstream_serializer #(.WIDTH(8), .DIV(1), .MSB_FIRST(1), .IDLE_BIT(1'b0)) u0 (
        .clk(clk), .reset(rst_n), .in_data(in_data), .in_valid(iv[0]), .in_ready(rdy[0]),
        .x(x[0]), .x_valid(xv[0]), .busy(busy[0]), .words_sent(ws[0]));
    bitstream_serializer #(.WIDTH(8), .DIV(3), .MSB_FIRST(1), .IDLE_BIT(1'b0)) u1 (
        .clk(clk), .reset(rst_n), .in_data(in_data), .in_valid(iv[1]), .in_ready(rdy[1]),
        .x(x[1]), .x_valid(xv[1]), .busy(busy[1]), .words_sent(ws[1]));
    bitstream_serializer #(.WIDTH(8), .DIV(1), .MSB_FIRST(0), .IDLE_BIT(1'b0)) u2 (
        .clk(clk), .reset(rst_n), .in_data(in_data), .in_valid(iv[2]), .in_ready(rdy[2]),
        .x(x[2]), .x_valid(xv[2]), .busy(busy[2]), .words_sent(ws[2]));

    initial clk = 0;
    always #5 clk = ~clk;

    // Reference model: a word in flight is described by its cycle index mt;
    // the bit shown is index mt/DIV, and x_valid marks mt%DIV == 0.
    int          mdiv [3] = '{1, 3, 1};
    bit          mmsb [3] = '{1'b1, 1'b1, 1'b0};
    bit          mhf  [3];
    bit          mbusy[3];
    logic [7:0]  mhold[3];
    logic [7:0]  mword[3];
    int          mt   [3];
    logic [31:0] mcnt [3];

    initial begin
        for (int i = 0; i < 3; i++) begin
            mhf[i] = 0; mbusy[i] = 0; mhold[i] = 0; mword[i] = 0; mt[i] = 0; mcnt[i] = 0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            if (!rst_n) begin
                mhf[i] = 0; mbusy[i] = 0; mt[i] = 0; mcnt[i] = 0;
            end else begin
                bit acc;
                acc = iv[i] && !mhf[i];
                if (mbusy[i]) begin
                    if (mt[i] == 8 * mdiv[i] - 1) begin
                        mcnt[i] = mcnt[i] + 1;
                        if (mhf[i]) begin
                            mword[i] = mhold[i]; mt[i] = 0; mhf[i] = 0;
                        end else begin
                            mbusy[i] = 0;
                        end
                    end else begin
                        mt[i] = mt[i] + 1;
                    end
                end else if (mhf[i]) begin
                    mword[i] = mhold[i]; mt[i] = 0; mhf[i] = 0; mbusy[i] = 1;
                end
                if (acc) begin
                    mhold[i] = in_data; mhf[i] = 1;
                end
            end
        end
    end

    function automatic logic exp_x(int i);
        int k;
        if (!mbusy[i]) return 1'b0;
        k = mt[i] / mdiv[i];
        return mmsb[i] ? mword[i][7 - k] : mword[i][k];
    endfunction

    // Per-cycle comparison of every instance against the model.
    always @(negedge clk) begin
        if (armed) begin
            for (int i = 0; i < 3; i++) begin
                logic ex, exv, eb, er;
                ex  = exp_x(i);
                exv = mbusy[i] && (mt[i] % mdiv[i] == 0);
                eb  = mbusy[i];
                er  = rst_n && !mhf[i];
                checks++;
                if (x[i] !== ex || xv[i] !== exv || busy[i] !== eb || rdy[i] !== er || ws[i] !== mcnt[i]) begin
                    errors++;
                    $display("FAIL cycle u%0d t=%0t: got x=%b xv=%b busy=%b rdy=%b ws=%0d, need x=%b xv=%b busy=%b rdy=%b ws=%0d",
                             i, $time, x[i], xv[i], busy[i], rdy[i], ws[i], ex, exv, eb, er, mcnt[i]);
                end
            end
        end
    end

    // Observation counters for the directed literal checks.
    logic [15:0] cap0, cap2;
    int bcnt0, bcnt1, pcnt0, pcnt1, ones1;
    always @(negedge clk) begin
        if (xv[0]) cap0 = {cap0[14:0], x[0]};
        if (xv[2]) cap2 = {cap2[14:0], x[2]};
        if (busy[0]) bcnt0++;
        if (busy[1]) bcnt1++;
        if (xv[0]) pcnt0++;
        if (xv[1]) pcnt1++;
        if (busy[1] && x[1]) ones1++;
    end

    task automatic clr();
        cap0 = 0; cap2 = 0; bcnt0 = 0; bcnt1 = 0; pcnt0 = 0; pcnt1 = 0; ones1 = 0;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, need %0h", name, act, exp);
        end
    endtask

    // Offer one word to all instances; each drops valid once it accepts.
    task automatic send(input logic [7:0] d);
        logic [2:0] acc;
        in_data = d;
        iv = 3'b111;
        for (int n = 0; n < 200 && iv != 0; n++) begin
            @(negedge clk);
            acc = iv & rdy;
            @(posedge clk);
            #1;
            iv = iv & ~acc;
        end
        chk("send_timeout", {29'd0, iv}, 32'd0);
        iv = 0;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (n < 1000 && (mbusy[0] || mbusy[1] || mbusy[2] || mhf[0] || mhf[1] || mhf[2])) begin
            @(posedge clk); #1; n++;
        end
        chk("idle_timeout", (n >= 1000) ? 32'd1 : 32'd0, 32'd0);
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 0; iv = 3'b111; in_data = 8'hAA;
        clr();
        @(posedge clk); #1;
        armed = 1;
        @(posedge clk); #1;
        // Reset held two cycles with valid high: nothing accepted, outputs idle.
        @(negedge clk);
        chk("rst_x", {29'd0, x}, 32'd0);
        chk("rst_xv", {29'd0, xv}, 32'd0);
        chk("rst_busy", {29'd0, busy}, 32'd0);
        chk("rst_rdy", {29'd0, rdy}, 32'd0);
        chk("rst_ws0", ws[0], 32'd0);
        @(posedge clk); #1;
        rst_n = 1; iv = 0;
        @(negedge clk);
        chk("rdy_after_rst", {29'd0, rdy}, 32'h7);
        repeat (3) @(posedge clk);
        #1;
        chk("no_accept_in_rst", {29'd0, busy}, 32'd0);

        // Single word 0x52.
        clr();
        send(8'h52);
        wait_idle();
        chk("single_msb_bits", {16'd0, 8'd0, cap0[7:0]}, 32'h52);
        chk("single_lsb_bits", {24'd0, cap2[7:0]}, 32'h4A);
        chk("single_busy_cycles", bcnt0, 32'd8);
        chk("single_valid_pulses", pcnt0, 32'd8);
        chk("div3_busy_cycles", bcnt1, 32'd24);
        chk("single_ws", ws[0], 32'd1);

        // DIV=3 on 0xF0: 12 high cycles, 8 pulses, 24 cycles long.
        clr();
        send(8'hF0);
        wait_idle();
        chk("div3_ones", ones1, 32'd12);
        chk("div3_pulses", pcnt1, 32'd8);
        chk("div3_len", bcnt1, 32'd24);
        chk("lsb_f0", {24'd0, cap2[7:0]}, 32'h0F);

        // LSB-first 0x01: first bit out is 1.
        clr();
        send(8'h01);
        wait_idle();
        chk("lsb_01", {24'd0, cap2[7:0]}, 32'h80);

        // Back-to-back A5, 3C: 16 contiguous bits.
        clr();
        send(8'hA5);
        send(8'h3C);
        wait_idle();
        chk("b2b_bits", {16'd0, cap0}, 32'hA53C);
        chk("b2b_busy_cycles", bcnt0, 32'd16);
        chk("b2b_ws", ws[0], 32'd5);
        chk("b2b_ws_div3", ws[1], 32'd5);

        // Randomised traffic with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk); #1;
            in_data = 8'($urandom);
            iv = 3'($urandom_range(0, 7));
            rst_n = ($urandom_range(0, 399) != 0);
        end
        rst_n = 1; iv = 0;
        wait_idle();

        // Reset mid-word with a second word waiting in hold.
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        send(8'hFF);
        send(8'h11);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        clr();
        @(negedge clk);
        chk("midrst_x", {31'd0, x[0]}, 32'd0);
        chk("midrst_ws", ws[0], 32'd0);
        chk("midrst_busy", {29'd0, busy}, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        chk("midrst_no_emit", pcnt0, 32'd0);
        chk("midrst_no_emit_div3", pcnt1, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
